// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM command front-end.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int unsigned ADDR_SIZE_DEFAULT = 8;
  localparam int unsigned FRAME_BITS        = ADDR_SIZE_DEFAULT + 2;

  function automatic int unsigned frame_bits(input int unsigned addr_size);
    return addr_size + 2;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO shift register: load puts the MSB on the line, then one bit per clock,
// then a trailing 0. done is high in the cycle whose edge emits that 0.
module spi_tx_serializer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         miso,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;

  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (clear) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (load) begin
      sr   <= {load_data[W-2:0], 1'b0};
      miso <= load_data[W-1];
      cnt  <= CW'(W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        miso <= sr[W-1];
        sr   <= {sr[W-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end else begin
        miso <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI slave front-end for the single-port RAM: deserialises MOSI command frames
// and serialises read data back on MISO.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int unsigned     NBITS    = frame_bits(ADDR_SIZE);
  localparam int unsigned     CNT_W    = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 2);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [ADDR_SIZE:0]   shift_sr;
  logic                 rx_done, frame_done, rd_addr_seen;
  logic                 in_shift, abort, chk_en, shift_en, last_bit;
  logic                 wait_tx, ser_load, ser_busy, ser_done, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && SS_n) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!SS_n) state_nxt = CHK_CMD;
        CHK_CMD: state_nxt = !MOSI ? WRITE : (rd_addr_seen ? READ_DATA : READ_ADD);
        default: state_nxt = state;
      endcase
    end
  end

  // Frame-phase strobes; the shift states are reused for the post-frame wait,
  // with rx_done/frame_done marking how far the frame has progressed.
  always_comb begin
    in_shift = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    abort    = (state != IDLE) && SS_n;
    chk_en   = (state == CHK_CMD) && !SS_n;
    shift_en = in_shift && !rx_done && !SS_n;
    last_bit = shift_en && (bit_cnt == LAST_CNT);
    wait_tx  = (state == READ_DATA) && rx_done && !frame_done && !ser_busy && !SS_n;
    ser_load = wait_tx && tx_valid;
    finish   = ser_done && !SS_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_sr     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_done      <= 1'b0;
      frame_done   <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= last_bit;
      if (last_bit) rx_data <= {shift_sr, MOSI};

      if (abort || state == IDLE) begin
        bit_cnt    <= '0;
        rx_done    <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        if (chk_en) shift_sr <= {{ADDR_SIZE{1'b0}}, MOSI};
        if (shift_en) begin
          shift_sr <= {shift_sr[ADDR_SIZE-1:0], MOSI};
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
        end
        if (last_bit) begin
          rx_done <= 1'b1;
          if (state != READ_DATA) frame_done <= 1'b1;
        end
        if (finish) frame_done <= 1'b1;
      end

      if (last_bit && state == READ_ADD) rd_addr_seen <= 1'b1;
      else if (finish)                    rd_addr_seen <= 1'b0;
    end
  end

  spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort),
    .load      (ser_load),
    .load_data (tx_data),
    .miso      (MISO),
    .busy      (ser_busy),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: stimulus queues expected rx words and MISO
// bytes, a monitor compares them whenever the DUT presents them.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic       clk, rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_check;

  typedef struct {
    logic [7:0] data;
    int         nb;
  } miso_exp_t;

  logic [9:0] rx_q[$];
  miso_exp_t  miso_q[$];
  int         total, bad;
  bit         ref_seen;

  spi_ram_ctrl #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: rx words on rx_valid; after a tracked tx_valid edge, 9 MISO samples
  // (nb data bits MSB first, zeros after); MISO must be 0 at all other times.
  initial begin
    int        win = 0;
    int        k = 0;
    miso_exp_t cur;
    logic [9:0] e;
    logic       eb;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        win = 0;
        continue;
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", {22'b0, rx_data}, {22'b0, e});
        end
      end
      if (tx_valid && tx_check && win == 0) begin
        if (miso_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miso_unexpected: got tx edge expected none");
        end else begin
          cur = miso_q.pop_front();
          win = 9;
          k   = 0;
        end
      end
      if (win > 0) begin
        eb = (k < cur.nb) ? cur.data[7-k] : 1'b0;
        check($sformatf("miso_bit%0d", k), {31'b0, MISO}, {31'b0, eb});
        k++;
        win--;
      end else begin
        check("miso_idle", {31'b0, MISO}, 32'd0);
      end
    end
  end

  task automatic frame_bits(input logic [9:0] w, input int abort_at, output bit aborted);
    aborted = 1'b0;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tx_check = 1'b0;
      tx_valid = (i < 9) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (i == abort_at) begin
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        aborted  = 1'b1;
        break;
      end
      MOSI = w[9-i];
    end
  endtask

  task automatic send_frame(input logic [9:0] w, input int abort_at, input int miso_abort,
                            input logic [7:0] rd_byte, input int d, input int hold);
    bit aborted;
    bit is_rd_data;
    int nb;
    is_rd_data = w[9] && ref_seen;
    frame_bits(w, abort_at, aborted);
    if (aborted) return;
    rx_q.push_back(w);
    if (w[9]) begin
      nb = is_rd_data ? miso_abort : 0;
      if (!is_rd_data) ref_seen = 1'b1;
      repeat (d) begin
        @(negedge clk);
        MOSI = 1'($urandom);
      end
      tx_valid = 1'b1;
      tx_data  = rd_byte;
      tx_check = 1'b1;
      miso_q.push_back('{rd_byte, nb});
      @(negedge clk);
      tx_valid = 1'b0;
      tx_check = 1'b0;
      tx_data  = 8'($urandom);
      if (is_rd_data && miso_abort < 8) begin
        repeat (miso_abort - 1) @(negedge clk);
        SS_n = 1'b1;
        return;
      end
      if (is_rd_data) ref_seen = 1'b0;
      repeat (8 + hold) @(negedge clk);
    end else begin
      repeat (1 + hold) @(negedge clk);
    end
    SS_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    total = 0; bad = 0; ref_seen = 1'b0;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    tx_valid = 1'b0; tx_check = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    check("rst_miso", {31'b0, MISO}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data", {22'b0, rx_data}, 32'd0);
    rst_n = 1'b1;

    send_frame(10'h005, 10, 8, 8'h00, 2, 1);   // write address
    send_frame(10'h1AA, 10, 8, 8'h00, 2, 0);   // write data
    send_frame(10'h205, 10, 8, 8'h5C, 3, 1);   // read address, tx_valid ignored
    send_frame(10'h3C3, 10, 8, 8'hAA, 2, 2);   // read data 0xAA
    send_frame(10'h300, 10, 8, 8'h55, 2, 0);   // seen cleared -> read address
    send_frame(10'h0F0, 5, 8, 8'h00, 2, 0);    // aborted after 5 bits
    send_frame(10'h003, 10, 8, 8'h00, 2, 0);
    send_frame(10'h3FF, 10, 3, 8'hB7, 4, 0);   // abort after 3 MISO bits
    send_frame(10'h312, 10, 8, 8'h69, 5, 1);   // still read data
    send_frame(10'h2AB, 9, 8, 8'h00, 2, 0);    // abort on 10th edge
    send_frame(10'h2AB, 10, 8, 8'h33, 2, 0);
    send_frame(10'h155, 0, 8, 8'h00, 2, 0);    // abort at command edge
    send_frame(10'h3E1, 10, 8, 8'hC4, 3, 0);

    for (int n = 0; n < 60; n++) begin
      logic [9:0] w;
      int ab_at, ma, d, hold;
      w     = 10'($urandom);
      ab_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : 10;
      ma    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      d     = int'($urandom_range(2, 5));
      hold  = int'($urandom_range(0, 3));
      send_frame(w, ab_at, ma, 8'($urandom), d, hold);
    end

    // Async reset during the rx_valid cycle.
    frame_bits(10'h0A5, 10, ab);
    rx_q.push_back(10'h0A5);
    @(posedge clk);
    #2;
    check("rstA_rx_valid_pre", {31'b0, rx_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstA_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rstA_rx_data", {22'b0, rx_data}, 32'd0);
    check("rstA_miso", {31'b0, MISO}, 32'd0);
    SS_n = 1'b1; tx_valid = 1'b0; ref_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Async reset while MISO is driving a 1.
    send_frame(10'h280, 10, 8, 8'h11, 2, 0);
    frame_bits(10'h3AA, 10, ab);
    rx_q.push_back(10'h3AA);
    repeat (2) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hAA; tx_check = 1'b1;
    miso_q.push_back('{8'hAA, 8});
    @(posedge clk);
    #2;
    check("rstB_miso_pre", {31'b0, MISO}, 32'd1);
    rst_n = 1'b0;
    tx_valid = 1'b0; tx_check = 1'b0;
    #1;
    check("rstB_miso", {31'b0, MISO}, 32'd0);
    check("rstB_rx_valid", {31'b0, rx_valid}, 32'd0);
    SS_n = 1'b1; ref_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send_frame(10'h2F0, 10, 8, 8'h99, 2, 0);   // seen cleared by reset -> read address
    send_frame(10'h3F0, 10, 8, 8'h96, 2, 1);

    repeat (12) @(negedge clk);
    check("rx_q_empty", rx_q.size(), 32'd0);
    check("miso_q_empty", miso_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
